// File: rtl/adapter_in_high_perf.sv
// Input adapter: takes the host word stream, checks the header/message framing
// for the selected operation and forwards the words to the Dilithium core through a small FIFO.
module adapter_in_high_perf #(
  parameter int w     = 64,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [1:0]   mode,
  input  logic [2:0]   sec_lvl,
  input  logic         valid_i,
  output logic         ready_i,
  input  logic [w-1:0] data_i,
  input  logic         last_i,
  output logic         dilithium_valid_i,
  input  logic         dilithium_ready_i,
  output logic [w-1:0] dilithium_data_i,
  output logic         done,
  output logic         error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [AW-1:0] LAST_PTR  = AW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [9:0]    CNT_MAX   = 10'h3FF;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_MSG,
    S_DRAIN,
    S_DONE,
    S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic          keygen_q, keygen_d;
  logic [9:0]    hdr_len_q, hdr_len_d;
  logic [9:0]    hdr_cnt_q, hdr_cnt_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic [w-1:0]  fifo_mem [DEPTH];
  logic          full;
  logic          empty;
  logic          wr_en;
  logic          rd_en;
  logic          hdr_final;

  // Header length in words for each operation; unknown security levels map to level 5.
  function automatic logic [9:0] hdr_len_f(input logic [1:0] m, input logic [2:0] s);
    logic [9:0] len;
    len = 10'd0;
    case (m)
      2'd0: len = 10'd4;
      2'd1: begin
        case (s)
          3'd2:    len = 10'd467;
          3'd3:    len = 10'd656;
          default: len = 10'd899;
        endcase
      end
      2'd2: begin
        case (s)
          3'd2:    len = 10'd316;
          3'd3:    len = 10'd500;
          default: len = 10'd608;
        endcase
      end
      default: len = 10'd0;
    endcase
    return len;
  endfunction

  assign full              = (count_q == FULL_CNT);
  assign empty             = (count_q == '0);
  assign ready_i           = ((state_q == S_HDR) || (state_q == S_MSG)) && !full;
  assign dilithium_valid_i = !empty;
  assign dilithium_data_i  = fifo_mem[rd_ptr_q];
  assign done              = done_q;
  assign error             = error_q;

  // A start pulse wins over any handshake in the same cycle.
  assign wr_en     = valid_i && ready_i && !start;
  assign rd_en     = dilithium_valid_i && dilithium_ready_i && !start;
  assign hdr_final = ((hdr_cnt_q + 10'd1) == hdr_len_q);

  always_comb begin
    state_d   = state_q;
    keygen_d  = keygen_q;
    hdr_len_d = hdr_len_q;
    hdr_cnt_d = hdr_cnt_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    done_d    = done_q;
    error_d   = error_q;

    if (wr_en) begin
      wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + AW'(1);
    end
    if (rd_en) begin
      rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + AW'(1);
    end
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        state_d = S_IDLE;
      end
      S_HDR: begin
        if (wr_en) begin
          if (hdr_cnt_q != CNT_MAX) begin
            hdr_cnt_d = hdr_cnt_q + 10'd1;
          end
          if (hdr_final) begin
            // Keygen has no message, so its last header word must carry last_i.
            if (keygen_q) begin
              state_d = last_i ? S_DRAIN : S_ERR;
            end else begin
              state_d = last_i ? S_DRAIN : S_MSG;
            end
          end else if (last_i) begin
            state_d = S_ERR;
          end
        end
      end
      S_MSG: begin
        if (wr_en && last_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_d == '0) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      S_ERR: begin
        state_d = S_ERR;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_ERR) begin
      error_d = 1'b1;
    end
    if (state_d == S_DONE) begin
      done_d = 1'b1;
    end

    if (start) begin
      state_d   = (mode == 2'd3) ? S_ERR : S_HDR;
      keygen_d  = (mode == 2'd0);
      hdr_len_d = hdr_len_f(mode, sec_lvl);
      hdr_cnt_d = '0;
      wr_ptr_d  = '0;
      rd_ptr_d  = '0;
      count_d   = '0;
      done_d    = 1'b0;
      error_d   = (mode == 2'd3);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      keygen_q  <= 1'b0;
      hdr_len_q <= '0;
      hdr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      keygen_q  <= keygen_d;
      hdr_len_q <= hdr_len_d;
      hdr_cnt_q <= hdr_cnt_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // Storage needs no reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      fifo_mem[wr_ptr_q] <= data_i;
    end
  end

endmodule
